fifo_rd_stream: RTL and testbench



---
 rtl/fifo_rd_stream.sv | 137 +++++++++++++
 tb/tb_fifo_rd_stream.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side adapter for the team FIFO: issues RREQ under a credit rule, absorbs the
// one-cycle read latency in a 2-entry skid buffer and presents a valid/ready stream.

module fifo_rd_stream_chk #(
  parameter int WIDTH = 8
) (
  input logic             clk_i,
  input logic             rst_i,
  input logic             e_i,
  input logic             rreq_i,
  input logic [1:0]       occ_i,
  input logic             inflight_i,
  input logic             out_valid_i,
  input logic             out_ready_i,
  input logic [WIDTH-1:0] out_data_i
);

  a_occ_range: assert property (@(posedge clk_i) disable iff (rst_i)
    occ_i <= 2'd2);

  a_no_overfill: assert property (@(posedge clk_i) disable iff (rst_i)
    !(inflight_i && (occ_i == 2'd2)));

  a_no_read_empty: assert property (@(posedge clk_i)
    !(rreq_i && e_i));

  a_hold_stalled: assert property (@(posedge clk_i) disable iff (rst_i)
    (out_valid_i && !out_ready_i) |=> (out_valid_i && $stable(out_data_i)));

endmodule

module fifo_rd_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             e,
  output logic             RREQ,
  input  logic [WIDTH-1:0] RD,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count
);

  logic [1:0]       occ_q;
  logic [1:0]       occ_d;
  logic             inflight_q;
  logic             head_q;
  logic             head_d;
  logic             tail_q;
  logic             tail_d;
  logic [WIDTH-1:0] mem_q [0:1];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             pop_s;
  logic             rreq_s;
  logic [2:0]       used_s;
  logic [2:0]       room_s;

  // Credit > 0 is evaluated as used < room so the arithmetic never goes negative.
  always_comb begin
    pop_s  = (occ_q != 2'd0) && out_ready;
    used_s = {1'b0, occ_q} + {2'b00, inflight_q};
    room_s = 3'd2 + {2'b00, pop_s};
    if (rst) begin
      rreq_s = 1'b0;
    end else if (e) begin
      rreq_s = 1'b0;
    end else begin
      rreq_s = (used_s < room_s);
    end
  end

  always_comb begin
    if (inflight_q && !pop_s) begin
      occ_d = occ_q + 2'd1;
    end else if (!inflight_q && pop_s) begin
      occ_d = occ_q - 2'd1;
    end else begin
      occ_d = occ_q;
    end
    if (pop_s) begin
      head_d  = ~head_q;
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      head_d  = head_q;
      count_d = count_q;
    end
    if (inflight_q) begin
      tail_d = ~tail_q;
    end else begin
      tail_d = tail_q;
    end
  end

  // A word in flight is always captured; the credit rule guarantees a free slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      count_q    <= '0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= rreq_s;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      if (inflight_q) begin
        mem_q[tail_q] <= RD;
      end
    end
  end

  assign RREQ      = rreq_s;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = mem_q[head_q];
  assign out_count = count_q;

  fifo_rd_stream_chk #(.WIDTH(WIDTH)) u_chk (
    .clk_i       (clk),
    .rst_i       (rst),
    .e_i         (e),
    .rreq_i      (rreq_s),
    .occ_i       (occ_q),
    .inflight_i  (inflight_q),
    .out_valid_i (out_valid),
    .out_ready_i (out_ready),
    .out_data_i  (out_data)
  );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-level FIFO + stream model checks two instances
// (16-bit and 4-bit counters) every cycle, with literal pins on directed scenarios.

module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       e;
  logic       out_ready;
  logic [7:0] RD;
  logic       rreq_a, rreq_b, valid_a, valid_b;
  logic [7:0] data_a, data_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  always #5 clk = ~clk;

  fifo_rd_stream #(.WIDTH(8), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .e(e), .RREQ(rreq_a), .RD(RD),
    .out_valid(valid_a), .out_ready(out_ready), .out_data(data_a), .out_count(cnt_a)
  );

  fifo_rd_stream #(.WIDTH(8), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .e(e), .RREQ(rreq_b), .RD(RD),
    .out_valid(valid_b), .out_ready(out_ready), .out_data(data_b), .out_count(cnt_b)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Behavioural model: FIFO contents, words sitting in the stream buffer, one pending read.
  logic [7:0] fifo_q[$];
  logic [7:0] obuf[$];
  bit         pend;
  logic [7:0] rd_word;
  int         mcnt;

  // Per-scenario trace of the model, pinned against hand-computed literals.
  int         ph_rreq, ph_first_rreq, ph_last_rreq;
  int         ph_valid, ph_first_valid, ph_last_valid, ph_occmax, ph_cyc;
  logic [7:0] ph_out[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_phase();
    ph_rreq = 0; ph_first_rreq = -1; ph_last_rreq = -1;
    ph_valid = 0; ph_first_valid = -1; ph_last_valid = -1;
    ph_occmax = 0; ph_cyc = 0;
    ph_out.delete();
  endtask

  task automatic step(input bit r, input bit rdy);
    bit         x_valid, x_pop, x_rreq;
    logic [7:0] x_data;
    @(negedge clk);
    rst       = r;
    out_ready = rdy;
    e         = (fifo_q.size() == 0);
    RD        = rd_word;
    #1;
    x_valid = (obuf.size() != 0);
    x_data  = x_valid ? obuf[0] : 8'h00;
    x_pop   = x_valid && rdy;
    x_rreq  = !r && !e && ((obuf.size() + int'(pend) - int'(x_pop)) < 2);
    check("valid_a", 32'(valid_a), 32'(x_valid));
    check("valid_b", 32'(valid_b), 32'(x_valid));
    check("rreq_a", 32'(rreq_a), 32'(x_rreq));
    check("rreq_b", 32'(rreq_b), 32'(x_rreq));
    check("count16", 32'(cnt_a), 32'(mcnt) & 32'h0000_FFFF);
    check("count4", 32'(cnt_b), 32'(mcnt) & 32'h0000_000F);
    if (x_valid) begin
      check("data_a", 32'(data_a), 32'(x_data));
      check("data_b", 32'(data_b), 32'(x_data));
    end
    if (x_rreq) begin
      ph_rreq++;
      if (ph_first_rreq < 0) ph_first_rreq = ph_cyc;
      ph_last_rreq = ph_cyc;
    end
    if (x_valid) begin
      ph_valid++;
      if (ph_first_valid < 0) ph_first_valid = ph_cyc;
      ph_last_valid = ph_cyc;
    end
    if (x_pop) ph_out.push_back(x_data);
    @(posedge clk);
    if (r) begin
      obuf.delete();
      pend    = 1'b0;
      mcnt    = 0;
      rd_word = 8'($urandom);
    end else begin
      if (x_pop) begin
        void'(obuf.pop_front());
        mcnt++;
      end
      if (pend) obuf.push_back(rd_word);
      if (x_rreq) begin
        rd_word = fifo_q.pop_front();
        pend    = 1'b1;
      end else begin
        rd_word = 8'($urandom);
        pend    = 1'b0;
      end
    end
    if (obuf.size() > ph_occmax) ph_occmax = obuf.size();
    ph_cyc++;
    cyc++;
  endtask

  task automatic do_reset();
    fifo_q.delete();
    step(1'b1, 1'b0);
    clear_phase();
  endtask

  initial begin
    logic [7:0] exp_seq[$];
    rst = 1'b1; out_ready = 1'b0; e = 1'b1; RD = 8'h00;
    pend = 1'b0; rd_word = 8'h00; mcnt = 0;
    repeat (2) @(posedge clk);
    clear_phase();

    // Reset state
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    #1;
    check("reset_valid", 32'(valid_a), 32'd0);
    check("reset_count", 32'(cnt_a), 32'd0);
    clear_phase();

    // Single word
    fifo_q.push_back(8'hA5);
    repeat (8) step(1'b0, 1'b1);
    check("single_rreq_cycles", 32'(ph_rreq), 32'd1);
    check("single_valid_cycles", 32'(ph_valid), 32'd1);
    check("single_latency", 32'(ph_first_valid - ph_first_rreq), 32'd2);
    check("single_pops", 32'(ph_out.size()), 32'd1);
    if (ph_out.size() == 1) check("single_data", 32'(ph_out[0]), 32'h0000_00A5);
    check("single_count", 32'(cnt_a), 32'd1);

    // Streaming
    do_reset();
    for (int i = 0; i < 16; i++) fifo_q.push_back(8'(i));
    repeat (24) step(1'b0, 1'b1);
    check("stream_rreq_cycles", 32'(ph_rreq), 32'd16);
    check("stream_rreq_run", 32'(ph_last_rreq - ph_first_rreq + 1), 32'd16);
    check("stream_valid_run", 32'(ph_last_valid - ph_first_valid + 1), 32'd16);
    check("stream_valid_cycles", 32'(ph_valid), 32'd16);
    check("stream_pops", 32'(ph_out.size()), 32'd16);
    for (int i = 0; i < 16 && i < ph_out.size(); i++) check("stream_order", 32'(ph_out[i]), 32'(i));
    check("stream_count", 32'(cnt_a), 32'd16);
    check("stream_count4", 32'(cnt_b), 32'd0);

    // Backpressure
    do_reset();
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'(8'h10 + i));
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      #1;
      if (i >= 1) begin
        check("bp_hold_valid", 32'(valid_a), 32'd1);
        check("bp_hold_data", 32'(data_a), 32'h0000_0010);
      end
    end
    check("bp_stall_rreq", 32'(ph_rreq), 32'd2);
    repeat (10) step(1'b0, 1'b1);
    check("bp_pops", 32'(ph_out.size()), 32'd4);
    for (int i = 0; i < 4 && i < ph_out.size(); i++) check("bp_order", 32'(ph_out[i]), 32'(8'h10 + i));

    // Alternating ready
    do_reset();
    exp_seq.delete();
    for (int i = 0; i < 8; i++) begin
      exp_seq.push_back(8'($urandom));
      fifo_q.push_back(exp_seq[i]);
    end
    for (int i = 0; i < 30; i++) step(1'b0, 1'(i % 2));
    check("alt_pops", 32'(ph_out.size()), 32'd8);
    for (int i = 0; i < 8 && i < ph_out.size(); i++) check("alt_order", 32'(ph_out[i]), 32'(exp_seq[i]));
    check("alt_occ_le2", 32'(ph_occmax <= 2), 32'd1);

    // Reset mid-burst: 0x20 buffered and 0x21 in flight are lost
    do_reset();
    for (int i = 0; i < 16; i++) fifo_q.push_back(8'(8'h20 + i));
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    #1;
    check("midrst_valid", 32'(valid_a), 32'd0);
    check("midrst_count", 32'(cnt_a), 32'd0);
    check("midrst_rreq", 32'(rreq_a), 32'd0);
    clear_phase();
    repeat (30) step(1'b0, 1'b1);
    check("midrst_pops", 32'(ph_out.size()), 32'd14);
    if (ph_out.size() > 0) check("midrst_resume", 32'(ph_out[0]), 32'h0000_0022);

    // Counter wrap on the 4-bit instance
    do_reset();
    for (int i = 0; i < 17; i++) fifo_q.push_back(8'(8'h40 + i));
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 1'b1);
      #1;
      if (mcnt == 15) check("wrap_15", 32'(cnt_b), 32'd15);
      if (mcnt == 16) check("wrap_0", 32'(cnt_b), 32'd0);
      if (mcnt == 17) check("wrap_1", 32'(cnt_b), 32'd1);
    end
    check("wrap_cnt16", 32'(cnt_a), 32'd17);

    // Randomized traffic with empty toggling and occasional resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 40) fifo_q.push_back(8'($urandom));
      step(1'($urandom_range(0, 99) < 1), 1'($urandom_range(0, 99) < 70));
    end
    check("rand_occ_le2", 32'(ph_occmax <= 2), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
